// File: rtl/onchip_ram_burst_bridge_if.sv
`default_nettype none
// ============================================================================
// Module   : onchip_ram_burst_bridge_if
// Purpose  : Avalon-MM burst slave side plus single-beat on-chip RAM side.
// Revision : 1.0 - initial release
// ============================================================================
interface onchip_ram_burst_bridge_if #(
    parameter int ADDR_W  = 13,
    parameter int DATA_W  = 32,
    parameter int BURST_W = 4
);
    logic [ADDR_W-1:0]   s_address;
    logic [BURST_W-1:0]  s_burstcount;
    logic                s_read;
    logic                s_write;
    logic [DATA_W/8-1:0] s_byteenable;
    logic [DATA_W-1:0]   s_writedata;
    logic                s_waitrequest;
    logic [DATA_W-1:0]   s_readdata;
    logic                s_readdatavalid;
    logic                s_error;
    logic                freeze;
    logic [ADDR_W-1:0]   m_address;
    logic                m_chipselect;
    logic                m_write;
    logic [DATA_W/8-1:0] m_byteenable;
    logic [DATA_W-1:0]   m_writedata;
    logic                m_clken;
    logic [DATA_W-1:0]   m_readdata;

    // Bridge view: accepts commands on s_*, drives the RAM on m_*.
    modport slave (
        input  s_address, s_burstcount, s_read, s_write, s_byteenable, s_writedata,
        input  freeze, m_readdata,
        output s_waitrequest, s_readdata, s_readdatavalid, s_error,
        output m_address, m_chipselect, m_write, m_byteenable, m_writedata, m_clken
    );

    // Environment view: the data master plus the RAM itself.
    modport master (
        output s_address, s_burstcount, s_read, s_write, s_byteenable, s_writedata,
        output freeze, m_readdata,
        input  s_waitrequest, s_readdata, s_readdatavalid, s_error,
        input  m_address, m_chipselect, m_write, m_byteenable, m_writedata, m_clken
    );
endinterface
`default_nettype wire

// File: rtl/onchip_ram_burst_bridge.sv
`default_nettype none
// ============================================================================
// Module   : onchip_ram_burst_bridge
// Purpose  : Splits Avalon-MM bursts into single RAM beats, traps out-of-range.
// Revision : 1.0 - initial release
// ============================================================================
module onchip_ram_burst_bridge #(
    parameter int                ADDR_W   = 13,
    parameter int                DATA_W   = 32,
    parameter int                DEPTH    = 5000,
    parameter int                BURST_W  = 4,
    parameter logic [DATA_W-1:0] OOR_DATA = 32'hDEADBEEF
) (
    input  wire logic                 clk,
    input  wire logic                 reset,
    onchip_ram_burst_bridge_if.slave  bus
);
    localparam logic [BURST_W-1:0] C_MAX_BURST = BURST_W'(2 ** (BURST_W - 1));
    localparam logic [BURST_W-1:0] C_ONE       = BURST_W'(1);
    localparam logic [ADDR_W:0]    C_DEPTH     = DEPTH[ADDR_W:0];

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RD_BURST = 2'd1,
        WR_BURST = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [BURST_W-1:0]  r_beats_left;
    logic [BURST_W-1:0]  w_beats_nxt;
    logic [ADDR_W-1:0]   r_addr;
    logic [ADDR_W-1:0]   w_addr_nxt;
    logic [ADDR_W-1:0]   w_issue_addr;
    logic [BURST_W-1:0]  w_burst_len;
    logic                w_issue_rd;
    logic                w_issue_wr;
    logic                w_in_range;
    logic                w_both_req;
    logic                w_waitreq;
    logic                r_rdv;
    logic                r_oor;
    logic                r_error;

    always_comb begin
        w_burst_len = bus.s_burstcount;
        if (bus.s_burstcount == '0) begin
            w_burst_len = C_ONE;
        end else if (bus.s_burstcount > C_MAX_BURST) begin
            w_burst_len = C_MAX_BURST;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_beats_nxt  = r_beats_left;
        w_addr_nxt   = r_addr;
        w_issue_addr = r_addr + 1'b1;
        w_issue_rd   = 1'b0;
        w_issue_wr   = 1'b0;
        w_both_req   = 1'b0;
        w_waitreq    = 1'b1;
        case (r_state)
            IDLE: begin
                w_waitreq    = bus.freeze;
                w_issue_addr = bus.s_address;
                if (!reset && !bus.freeze && (bus.s_read || bus.s_write)) begin
                    w_addr_nxt  = bus.s_address;
                    w_beats_nxt = w_burst_len - C_ONE;
                    // A simultaneous read+write is served as the write only.
                    if (bus.s_write) begin
                        w_issue_wr = 1'b1;
                        w_both_req = bus.s_read;
                        if (w_burst_len != C_ONE) begin
                            w_state_nxt = WR_BURST;
                        end
                    end else begin
                        w_issue_rd = 1'b1;
                        if (w_burst_len != C_ONE) begin
                            w_state_nxt = RD_BURST;
                        end
                    end
                end
            end
            RD_BURST: begin
                // beats_left==0 is the trailing busy cycle after the last beat.
                if (r_beats_left == '0) begin
                    w_state_nxt = IDLE;
                end else if (!bus.freeze) begin
                    w_issue_rd  = 1'b1;
                    w_addr_nxt  = w_issue_addr;
                    w_beats_nxt = r_beats_left - C_ONE;
                end
            end
            WR_BURST: begin
                w_waitreq = bus.freeze;
                if (!bus.freeze && bus.s_write) begin
                    w_issue_wr  = 1'b1;
                    w_addr_nxt  = w_issue_addr;
                    w_beats_nxt = r_beats_left - C_ONE;
                    if (r_beats_left == C_ONE) begin
                        w_state_nxt = IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign w_in_range = ({1'b0, w_issue_addr} < C_DEPTH);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= IDLE;
            r_beats_left <= '0;
            r_addr       <= '0;
            r_rdv        <= 1'b0;
            r_oor        <= 1'b0;
            r_error      <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_beats_left <= w_beats_nxt;
            r_addr       <= w_addr_nxt;
            r_rdv        <= w_issue_rd;
            r_oor        <= w_issue_rd && !w_in_range;
            r_error      <= r_error | w_both_req
                          | ((w_issue_rd || w_issue_wr) && !w_in_range);
        end
    end

    assign bus.m_address       = w_issue_addr;
    assign bus.m_chipselect    = (w_issue_rd || w_issue_wr) && w_in_range;
    assign bus.m_write         = w_issue_wr && w_in_range;
    assign bus.m_byteenable    = bus.s_byteenable;
    assign bus.m_writedata     = bus.s_writedata;
    assign bus.m_clken         = 1'b1;

    assign bus.s_waitrequest   = reset | w_waitreq;
    assign bus.s_readdatavalid = r_rdv;
    assign bus.s_readdata      = r_oor ? OOR_DATA : bus.m_readdata;
    assign bus.s_error         = r_error;
endmodule
`default_nettype wire
